// File: rtl/occupancy_display.sv
// occupancy_display: converts the lot count to BCD and scans it onto a 4-digit seven-segment display.
module occupancy_display #(
  parameter int CAPACITY    = 200,
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [11:0] bcd,
  output logic       full,
  output logic       empty
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [7:0] CAP = 8'(CAPACITY);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] LETTER_F = 7'b0001110;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    last_q, last_d, sh_q, sh_d;
  logic [11:0]   scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [2:0]    it_q, it_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    dig_q, dig_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = BLANK;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    it_d    = it_q;
    bcd_d   = bcd_q;
    for (int i = 0; i < 3; i++)
      adj[4*i +: 4] = scr_q[4*i +: 4] + ((scr_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    case (state_q)
      IDLE: if (count != last_q) begin
        sh_d    = count;
        last_d  = count;
        scr_d   = '0;
        it_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {scr_d, sh_d} = {adj, sh_q} << 1;
        it_d    = it_q + 3'd1;
        state_d = (it_q == 3'd7) ? LOAD : SHIFT;
      end
      LOAD: begin
        bcd_d   = scr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    full_d  = count >= CAP;
    empty_d = count == 8'd0;
    ref_d   = (ref_q == REF_MAX) ? '0 : ref_q + 1'b1;
    dig_d   = (ref_q == REF_MAX) ? dig_q + 2'd1 : dig_q;
    // decode from the next digit index so anode and segments switch on the same edge
    an_d    = ~(4'b0001 << dig_d);
    seg_d   = (dig_d == 2'd0) ? enc(bcd_q[3:0]) :
              (dig_d == 2'd1) ? ((bcd_q[11:4] == 8'd0) ? BLANK : enc(bcd_q[7:4])) :
              (dig_d == 2'd2) ? ((bcd_q[11:8] == 4'd0) ? BLANK : enc(bcd_q[11:8])) :
              (full_q ? LETTER_F : BLANK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= '0;
      sh_q    <= '0;
      scr_q   <= '0;
      it_q    <= '0;
      bcd_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ref_q   <= '0;
      dig_q   <= '0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      it_q    <= it_d;
      bcd_q   <= bcd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ref_q   <= ref_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = 1'b1;
  assign bcd   = bcd_q;
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: tb/tb_occupancy_display.sv
// tb_occupancy_display: directed checks of conversion latency, flags, digit scan and reset behaviour.
module tb_occupancy_display;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] count = 8'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [11:0] bcd;
  logic       full, empty;
  int tests = 0;
  int fails = 0;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] SF = 7'b0001110;

  occupancy_display #(.CAPACITY(200), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .count(count), .an(an), .seg(seg),
    .dp(dp), .bcd(bcd), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic capture(input logic [3:0] a, output logic [6:0] s, output bit got);
    got = 1'b0;
    s = 'x;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (an === a) begin
        s = seg;
        got = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    logic [6:0] exp_seg [4];
    logic [6:0] s;
    bit g;
    reset = 1'b0;
    count = 8'd0;
    @(negedge clk);
    tests++;
    if (an !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1) begin
      fails++;
      $display("FAIL reset_display: an=%b seg=%b dp=%b required an=1110 seg=1000000 dp=1", an, seg, dp);
    end
    tests++;
    if (bcd !== 12'h000 || full !== 1'b0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_flags: bcd=%h full=%b empty=%b required bcd=000 full=0 empty=1", bcd, full, empty);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (empty !== 1'b1 || bcd !== 12'h000) begin
      fails++;
      $display("FAIL release_idle: empty=%b bcd=%h required empty=1 bcd=000", empty, bcd);
    end
    repeat (12) @(negedge clk);
    tests++;
    if (bcd !== 12'h000) begin
      fails++;
      $display("FAIL no_conversion: bcd=%h required 000", bcd);
    end
    exp_seg = '{7'b1000000, BL, BL, BL};
    for (int d = 0; d < 4; d++) begin
      capture(~(4'b0001 << d), s, g);
      tests++;
      if (!g || s !== exp_seg[d]) begin
        fails++;
        $display("FAIL reset_digit%0d: seg=%b found=%0d required %b", d, s, g, exp_seg[d]);
      end
    end
  endtask

  task automatic test_convert_3;
    logic [6:0] exp_seg [4];
    logic [6:0] s;
    bit g;
    @(negedge clk);
    count = 8'd3;
    @(negedge clk);
    tests++;
    if (empty !== 1'b0) begin
      fails++;
      $display("FAIL empty_latency: empty=%b required 0", empty);
    end
    repeat (8) @(negedge clk);
    tests++;
    if (bcd !== 12'h000) begin
      fails++;
      $display("FAIL early_bcd_3: bcd=%h required 000 after 9 edges", bcd);
    end
    @(negedge clk);
    tests++;
    if (bcd !== 12'h003) begin
      fails++;
      $display("FAIL bcd_3: bcd=%h required 003 after 10 edges", bcd);
    end
    @(negedge clk);
    exp_seg = '{7'b0110000, BL, BL, BL};
    for (int d = 0; d < 4; d++) begin
      capture(~(4'b0001 << d), s, g);
      tests++;
      if (!g || s !== exp_seg[d]) begin
        fails++;
        $display("FAIL three_digit%0d: seg=%b found=%0d required %b", d, s, g, exp_seg[d]);
      end
    end
  endtask

  task automatic test_values;
    logic [7:0]  cv [3];
    logic [11:0] eb [3];
    logic        ef [3];
    logic [6:0]  es [3][4];
    logic [6:0]  s;
    bit g;
    cv = '{8'd255, 8'd199, 8'd200};
    eb = '{12'h255, 12'h199, 12'h200};
    ef = '{1'b1, 1'b0, 1'b1};
    es = '{'{7'b0010010, 7'b0010010, 7'b0100100, SF},
           '{7'b0010000, 7'b0010000, 7'b1111001, BL},
           '{7'b1000000, 7'b1000000, 7'b0100100, SF}};
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      count = cv[v];
      @(negedge clk);
      tests++;
      if (full !== ef[v] || empty !== 1'b0) begin
        fails++;
        $display("FAIL flags_%0d: full=%b empty=%b required full=%b empty=0", cv[v], full, empty, ef[v]);
      end
      repeat (9) @(negedge clk);
      tests++;
      if (bcd !== eb[v]) begin
        fails++;
        $display("FAIL bcd_%0d: bcd=%h required %h", cv[v], bcd, eb[v]);
      end
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        capture(~(4'b0001 << d), s, g);
        tests++;
        if (!g || s !== es[v][d]) begin
          fails++;
          $display("FAIL show_%0d_digit%0d: seg=%b found=%0d required %b", cv[v], d, s, g, es[v][d]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int  k10 = -1;
    int  k12 = -1;
    bit  saw11 = 1'b0;
    logic [6:0] exp_seg [4];
    logic [6:0] s;
    bit g;
    @(negedge clk);
    count = 8'd10;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bcd === 12'h011) saw11 = 1'b1;
      if (bcd === 12'h010 && k10 < 0) k10 = k;
      if (bcd === 12'h012 && k12 < 0) k12 = k;
      if (k == 1) count = 8'd11;
      if (k == 2) count = 8'd12;
    end
    tests++;
    if (k10 != 10) begin
      fails++;
      $display("FAIL b2b_first: bcd=010 at edge %0d required 10", k10);
    end
    tests++;
    if (k12 != 20) begin
      fails++;
      $display("FAIL b2b_second: bcd=012 at edge %0d required 20", k12);
    end
    tests++;
    if (saw11) begin
      fails++;
      $display("FAIL b2b_skip: bcd=011 seen=1 required 0");
    end
    exp_seg = '{7'b0100100, 7'b1111001, BL, BL};
    for (int d = 0; d < 4; d++) begin
      capture(~(4'b0001 << d), s, g);
      tests++;
      if (!g || s !== exp_seg[d]) begin
        fails++;
        $display("FAIL twelve_digit%0d: seg=%b found=%0d required %b", d, s, g, exp_seg[d]);
      end
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    count = 8'd57;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if (bcd !== 12'h000 || full !== 1'b0 || empty !== 1'b1 || an !== 4'b1110 || seg !== 7'b1000000) begin
      fails++;
      $display("FAIL async_reset: bcd=%h full=%b empty=%b an=%b seg=%b required 000 0 1 1110 1000000",
               bcd, full, empty, an, seg);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (9) @(negedge clk);
    tests++;
    if (bcd !== 12'h000) begin
      fails++;
      $display("FAIL early_bcd_57: bcd=%h required 000 after 9 edges", bcd);
    end
    @(negedge clk);
    tests++;
    if (bcd !== 12'h057) begin
      fails++;
      $display("FAIL bcd_57: bcd=%h required 057 after 10 edges", bcd);
    end
  endtask

  task automatic test_scan;
    logic [3:0] ea;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) @(negedge clk);
      else #1;
      ea = ~(4'b0001 << ((k / 4) % 4));
      tests++;
      if (an !== ea || $countones(~an) != 1) begin
        fails++;
        $display("FAIL scan_%0d: an=%b required %b", k, an, ea);
      end
    end
  endtask

  initial begin
    test_reset;
    test_convert_3;
    test_values;
    test_back_to_back;
    test_reset_mid;
    test_scan;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
